pcie_mem_responder: RTL and testbench

Memory-side responder for the PCIe IO endpoint's memory request/response interface. It accepts read and write requests (single beat or burst) and executes them against an internal synchronous BAR memory. It returns one response per write burst and one response per 64-bit read beat. It sits between the endpoint's request port and local storage, and is the target end of that interface.

---
 rtl/pcie_dma_pkg.sv | 28 ++
 rtl/pcie_mem_ram.sv | 26 ++
 rtl/pcie_mem_responder.sv | 150 +++++++++++++++
 tb/tb_pcie_mem_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_dma_pkg.sv
// Shared types and helpers for the PCIe memory responder: FSM encoding and
// read burst beat arithmetic.
package pcie_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WR_RESP,
        ST_RD_ISSUE,
        ST_RD_DATA,
        ST_RD_RESP
    } state_t;

    // A byte count of zero on the request encodes the maximum burst
    localparam int unsigned LEN_ZERO_BYTES = 1024;

    // Number of 64-bit beats touched by a burst of 'bytes' starting at byte
    // offset addr_lo within the first word (1..129).
    function automatic logic [7:0] beat_count(input logic [2:0] addr_lo,
                                              input logic [9:0] bytes);
        logic [11:0] len;
        logic [11:0] total;
        len   = (bytes == 10'd0) ? 12'(LEN_ZERO_BYTES) : {2'b00, bytes};
        total = len + {9'd0, addr_lo} + 12'd7;
        return total[10:3];
    endfunction

endpackage

// File: rtl/pcie_mem_ram.sv
// Single-port synchronous 64-bit RAM with per-byte write enables and a
// registered read port (one cycle latency).
module pcie_mem_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we && be[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pcie_mem_responder.sv
// Target end of the endpoint memory request/response interface: executes
// single and burst reads/writes against the internal BAR memory.
module pcie_mem_responder
    import pcie_dma_pkg::*;
#(
    parameter int MEM_BYTES = 8192
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    output logic        o_req_mem_ready,
    input  logic        i_req_mem_valid,
    input  logic        i_req_mem_64,
    input  logic        i_req_mem_write,
    input  logic [9:0]  i_req_mem_bytes,
    input  logic [12:0] i_req_mem_addr,
    input  logic [7:0]  i_req_mem_strob,
    input  logic [63:0] i_req_mem_data,
    input  logic        i_req_mem_last,
    output logic [63:0] o_resp_mem_data,
    output logic        o_resp_mem_valid,
    output logic        o_resp_mem_fault,
    input  logic        i_resp_mem_ready
);

    localparam int WORDS = MEM_BYTES / 8;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t      state_reg, state_next;
    logic [13:0] ptr_reg;
    logic [7:0]  count_reg;
    logic        fault_reg;
    logic [63:0] data_reg;
    logic [63:0] ram_rdata;
    logic        unused_access_size;

    // The full word is always returned, so the access size is informational
    assign unused_access_size = i_req_mem_64;

    logic        req_fire;
    logic        resp_fire;
    logic        wr_fire;
    logic        in_range;
    logic [13:0] beat_ptr;

    // The first beat addresses RAM straight from the request, later beats use ptr
    assign beat_ptr  = (state_reg == ST_IDLE) ? {4'd0, i_req_mem_addr[12:3]} : ptr_reg;
    assign in_range  = beat_ptr < 14'(WORDS);
    assign req_fire  = i_req_mem_valid && o_req_mem_ready;
    assign resp_fire = o_resp_mem_valid && i_resp_mem_ready;
    assign wr_fire   = req_fire && ((state_reg == ST_WRITE) || i_req_mem_write);

    pcie_mem_ram #(
        .WORDS(WORDS),
        .AW   (AW)
    ) u_ram (
        .clk  (i_clk),
        .we   (wr_fire && in_range),
        .be   (i_req_mem_strob),
        .addr (beat_ptr[AW-1:0]),
        .wdata(i_req_mem_data),
        .rdata(ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    if (i_req_mem_write) begin
                        state_next = i_req_mem_last ? ST_WR_RESP : ST_WRITE;
                    end else begin
                        state_next = ST_RD_ISSUE;
                    end
                end
            end
            ST_WRITE:    if (req_fire && i_req_mem_last) state_next = ST_WR_RESP;
            ST_WR_RESP:  if (resp_fire) state_next = ST_IDLE;
            ST_RD_ISSUE: state_next = ST_RD_DATA;
            ST_RD_DATA:  state_next = ST_RD_RESP;
            ST_RD_RESP: begin
                if (resp_fire) begin
                    state_next = (count_reg == 8'd1) ? ST_IDLE : ST_RD_ISSUE;
                end
            end
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            ptr_reg   <= '0;
            count_reg <= '0;
            fault_reg <= 1'b0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_fire) begin
                        if (i_req_mem_write) begin
                            ptr_reg   <= beat_ptr + 14'd1;
                            fault_reg <= !in_range;
                        end else begin
                            ptr_reg   <= beat_ptr;
                            count_reg <= beat_count(i_req_mem_addr[2:0], i_req_mem_bytes);
                            fault_reg <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (req_fire) begin
                        ptr_reg   <= ptr_reg + 14'd1;
                        fault_reg <= fault_reg || !in_range;
                    end
                end
                ST_WR_RESP: begin
                    if (resp_fire) fault_reg <= 1'b0;
                end
                ST_RD_DATA: begin
                    data_reg  <= in_range ? ram_rdata : 64'd0;
                    fault_reg <= !in_range;
                end
                ST_RD_RESP: begin
                    if (resp_fire) begin
                        count_reg <= count_reg - 8'd1;
                        ptr_reg   <= ptr_reg + 14'd1;
                        fault_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response registers are untouched while a response waits, so it holds
    always_comb begin
        o_req_mem_ready  = i_nrst && ((state_reg == ST_IDLE) || (state_reg == ST_WRITE));
        o_resp_mem_valid = (state_reg == ST_WR_RESP) || (state_reg == ST_RD_RESP);
        o_resp_mem_data  = (state_reg == ST_RD_RESP) ? data_reg : 64'd0;
        o_resp_mem_fault = o_resp_mem_valid && fault_reg;
    end

endmodule

// File: tb/tb_pcie_mem_responder.sv
// Randomized and directed bench for pcie_mem_responder, checked against a
// byte-array model of the BAR memory.
module tb_pcie_mem_responder;

    localparam int MEMB = 4096;

    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic        req_ready;
    logic        req_valid = 1'b0;
    logic        req_64 = 1'b0;
    logic        req_write = 1'b0;
    logic [9:0]  req_bytes = '0;
    logic [12:0] req_addr = '0;
    logic [7:0]  req_strob = '0;
    logic [63:0] req_data = '0;
    logic        req_last = 1'b0;
    logic [63:0] resp_data;
    logic        resp_valid;
    logic        resp_fault;
    logic        resp_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0]  ref_mem [0:MEMB-1];
    logic [63:0] wq_data [$];
    logic [7:0]  wq_strb [$];

    pcie_mem_responder #(.MEM_BYTES(MEMB)) dut (
        .i_clk           (i_clk),
        .i_nrst          (i_nrst),
        .o_req_mem_ready (req_ready),
        .i_req_mem_valid (req_valid),
        .i_req_mem_64    (req_64),
        .i_req_mem_write (req_write),
        .i_req_mem_bytes (req_bytes),
        .i_req_mem_addr  (req_addr),
        .i_req_mem_strob (req_strob),
        .i_req_mem_data  (req_data),
        .i_req_mem_last  (req_last),
        .o_resp_mem_data (resp_data),
        .o_resp_mem_valid(resp_valid),
        .o_resp_mem_fault(resp_fault),
        .i_resp_mem_ready(resp_ready)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v = '0;
        if (w * 8 >= MEMB) return 64'd0;
        for (int i = 0; i < 8; i++) v[i*8 +: 8] = ref_mem[w*8 + i];
        return v;
    endfunction

    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        @(negedge i_clk);
        while (!resp_valid && lat < 50) begin
            lat++;
            @(negedge i_clk);
        end
        if (!resp_valid) chk({tag, "_timeout"}, resp_valid, 1);
    endtask

    // Burst write of the queued beats starting at addr, plus its response
    task automatic do_write(input logic [12:0] addr);
        int n = wq_data.size();
        int w0 = int'(addr) / 8;
        bit exp_fault = 0;
        int lat;
        for (int b = 0; b < n; b++) begin
            if ((w0 + b) * 8 >= MEMB) exp_fault = 1;
            else for (int i = 0; i < 8; i++)
                if (wq_strb[b][i]) ref_mem[(w0 + b)*8 + i] = wq_data[b][i*8 +: 8];
        end
        for (int b = 0; b < n; b++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_64    = 1'($urandom_range(0, 1));
            req_addr  = (b == 0) ? addr : 13'($urandom);
            req_bytes = 10'(n * 8);
            req_data  = wq_data[b];
            req_strob = wq_strb[b];
            req_last  = (b == n - 1);
            @(negedge i_clk);
            chk("wr_req_ready", req_ready, 1);
            @(posedge i_clk); #1;
            if (b != n - 1 && $urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(posedge i_clk); #1;
            end
        end
        req_valid = 1'b0;
        req_last  = 1'b0;
        wait_valid("wr_resp", lat);
        chk("wr_resp_lat", 64'(lat), 0);
        chk("wr_resp_data", resp_data, 0);
        chk("wr_resp_fault", resp_fault, exp_fault);
        $display("[TB] write addr=%h beats=%0d fault=%0b", addr, n, resp_fault);
        resp_ready = 1'b1;
        @(posedge i_clk); #1;
        resp_ready = 1'b0;
        wq_data.delete();
        wq_strb.delete();
    endtask

    // Read burst; optional stall on hold_beat, reset on rst_beat, random backpressure
    task automatic do_read(input logic [12:0] addr, input logic [9:0] bytes,
                           input int hold_beat, input int hold_cyc,
                           input int rst_beat, input bit rand_bp);
        int len = (bytes == 0) ? 1024 : int'(bytes);
        int nb = (int'(addr[2:0]) + len + 7) / 8;
        int w0 = int'(addr) / 8;
        int lat;
        int w;
        logic [63:0] held;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_64    = 1'($urandom_range(0, 1));
        req_addr  = addr;
        req_bytes = bytes;
        req_last  = 1'($urandom_range(0, 1));
        @(negedge i_clk);
        chk("rd_req_ready", req_ready, 1);
        @(posedge i_clk); #1;
        req_valid = 1'b0;
        req_last  = 1'b0;
        for (int b = 0; b < nb; b++) begin
            w = w0 + b;
            wait_valid("rd_beat", lat);
            chk("rd_lat", 64'(lat), 2);
            chk("rd_data", resp_data, ref_word(w));
            chk("rd_fault", resp_fault, (w * 8 >= MEMB));
            chk("rd_req_ready_busy", req_ready, 0);
            if (b == rst_beat) begin
                i_nrst = 1'b0;
                #1;
                chk("rst_ready", req_ready, 0);
                chk("rst_valid", resp_valid, 0);
                chk("rst_fault", resp_fault, 0);
                chk("rst_data", resp_data, 0);
                @(negedge i_clk);
                chk("rst_valid_next", resp_valid, 0);
                @(posedge i_clk); #1;
                i_nrst = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    @(negedge i_clk);
                    chk("post_rst_valid", resp_valid, 0);
                    chk("post_rst_ready", req_ready, 1);
                end
                $display("[TB] read addr=%h aborted by reset at beat %0d", addr, b);
                @(posedge i_clk); #1;
                return;
            end
            if (b == hold_beat) begin
                held = resp_data;
                for (int c = 0; c < hold_cyc; c++) begin
                    @(posedge i_clk);
                    @(negedge i_clk);
                    chk("hold_data", resp_data, held);
                    chk("hold_valid", resp_valid, 1);
                    chk("hold_req_ready", req_ready, 0);
                end
            end else if (rand_bp) begin
                repeat ($urandom_range(0, 2)) @(negedge i_clk);
            end
            resp_ready = 1'b1;
            @(posedge i_clk); #1;
            resp_ready = 1'b0;
        end
        @(negedge i_clk);
        chk("rd_done_valid", resp_valid, 0);
        chk("rd_done_ready", req_ready, 1);
        $display("[TB] read addr=%h bytes=%0d beats=%0d", addr, bytes, nb);
        @(posedge i_clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_valid", resp_valid, 0);
        chk("reset_fault", resp_fault, 0);
        chk("reset_data", resp_data, 0);
        @(posedge i_clk); #1;
        i_nrst = 1'b1;
        @(negedge i_clk);
        chk("idle_ready", req_ready, 1);
        chk("idle_valid", resp_valid, 0);
        @(posedge i_clk); #1;

        // Fill the whole memory so every later read has a defined expectation
        for (int i = 0; i < MEMB / 8; i++) begin
            wq_data.push_back({$urandom, $urandom});
            wq_strb.push_back(8'hFF);
        end
        do_write(13'h000);

        wq_data.push_back(64'h1122334455667788); wq_strb.push_back(8'hFF);
        do_write(13'h010);
        do_read(13'h010, 10'd8, -1, 0, -1, 0);

        wq_data.push_back(64'hAAAAAAAAAAAAAAAA); wq_strb.push_back(8'h0F);
        do_write(13'h010);
        do_read(13'h010, 10'd4, -1, 0, -1, 0);

        wq_data.push_back(64'd1); wq_strb.push_back(8'hFF);
        wq_data.push_back(64'd2); wq_strb.push_back(8'hFF);
        wq_data.push_back(64'd3); wq_strb.push_back(8'hFF);
        do_write(13'h100);
        do_read(13'h104, 10'd16, -1, 0, -1, 0);

        do_read(13'h0FF8, 10'd16, -1, 0, -1, 0);
        wq_data.push_back({$urandom, $urandom}); wq_strb.push_back(8'hFF);
        do_write(13'h1000);
        do_read(13'h000, 10'd8, -1, 0, -1, 0);

        do_read(13'h000, 10'd0, 6, 5, -1, 0);

        do_read(13'h000, 10'd80, -1, 0, 2, 0);
        wq_data.push_back({$urandom, $urandom}); wq_strb.push_back(8'($urandom));
        do_write(13'h200);
        do_read(13'h200, 10'd8, -1, 0, -1, 0);

        for (int t = 0; t < 30; t++) begin
            logic [12:0] a;
            a = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(MEMB - 64, 8191))
                                            : 13'($urandom_range(0, MEMB - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < int'($urandom_range(1, 4)); b++) begin
                    wq_data.push_back({$urandom, $urandom});
                    wq_strb.push_back(8'($urandom));
                end
                do_write(a);
            end else begin
                do_read(a, ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 64)),
                        -1, 0, -1, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
